// File: rtl/calc_unit_arbiter_if.sv
// Handshake bundle between the eight axis requesters / shared arithmetic unit and the arbiter.
// Macro CALC_ARB_PRIO_EN adds the per-axis priority mask.
interface calc_unit_arbiter_if #(
    parameter int W = 32
);
    logic                flush;
    logic [7:0]          req;
    logic [7:0][W-1:0]   a;
    logic [7:0][W-1:0]   b;
    logic [7:0]          gnt;
    logic                op_valid;
    logic [2:0]          op_tag;
    logic [W-1:0]        op_a;
    logic [W-1:0]        op_b;
    logic                ret_valid;
    logic [2:0]          ret_tag;
    logic [W-1:0]        ret_data;
    logic [7:0][W-1:0]   res;
    logic [7:0]          res_valid;
    logic [7:0]          busy;
    logic                error;
`ifdef CALC_ARB_PRIO_EN
    logic [7:0]          prio;
`endif

    modport master (
`ifdef CALC_ARB_PRIO_EN
        output prio,
`endif
        output flush, req, a, b, ret_valid, ret_tag, ret_data,
        input  gnt, op_valid, op_tag, op_a, op_b, res, res_valid, busy, error
    );

    modport slave (
`ifdef CALC_ARB_PRIO_EN
        input  prio,
`endif
        input  flush, req, a, b, ret_valid, ret_tag, ret_data,
        output gnt, op_valid, op_tag, op_a, op_b, res, res_valid, busy, error
    );
endinterface

// File: rtl/calc_unit_arbiter.sv
// Round-robin sharing of one pipelined arithmetic unit among 8 axes, with tag-routed results
// and a flush that drains the unit. Macro CALC_ARB_PRIO_EN restricts arbitration to prio & elig.
//
// state | meaning
// RUN   | arbitrate and issue, accept returned results
// DRAIN | flush in progress: no grants, returns ignored until the unit pipeline is empty
module calc_unit_arbiter #(
    parameter int W   = 32,
    parameter int LAT = 4
) (
    input  logic               clk_i,
    input  logic               sclr_i,
    calc_unit_arbiter_if.slave bus
);
    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state_q;
    logic [2:0]        ptr_q;
    logic [3:0]        cnt_q;
    logic [7:0]        busy_q;
    logic [7:0]        gnt_q;
    logic [7:0]        res_valid_q;
    logic              op_valid_q;
    logic              error_q;
    logic [2:0]        op_tag_q;
    logic [W-1:0]      op_a_q;
    logic [W-1:0]      op_b_q;
    logic [7:0][W-1:0] res_q;

    logic [7:0]        elig;
    logic [7:0]        cand;
    logic [2:0]        idx_c;
    logic              pick_any_d;
    logic [2:0]        pick_idx_d;
    logic              ret_ok;
    logic [7:0]        ret_clr;
    logic [7:0]        issue_set;

    assign elig = bus.req & ~busy_q;
`ifdef CALC_ARB_PRIO_EN
    assign cand = ((elig & bus.prio) != 8'h00) ? (elig & bus.prio) : elig;
`else
    assign cand = elig;
`endif

    // Scan ptr+1 .. ptr+8 so the last grantee is the final candidate.
    always_comb begin
        pick_any_d = 1'b0;
        pick_idx_d = ptr_q;
        idx_c      = ptr_q;
        for (int off = 1; off <= 8; off++) begin
            idx_c = ptr_q + 3'(off);
            if (!pick_any_d && cand[idx_c]) begin
                pick_any_d = 1'b1;
                pick_idx_d = idx_c;
            end
        end
    end

    assign ret_ok    = bus.ret_valid & busy_q[bus.ret_tag];
    assign ret_clr   = ret_ok ? (8'b1 << bus.ret_tag) : 8'h00;
    assign issue_set = pick_any_d ? (8'b1 << pick_idx_d) : 8'h00;

    always_ff @(posedge clk_i) begin
        if (sclr_i) begin
            state_q     <= RUN;
            ptr_q       <= 3'd7;
            cnt_q       <= 4'd0;
            busy_q      <= 8'h00;
            gnt_q       <= 8'h00;
            res_valid_q <= 8'h00;
            op_valid_q  <= 1'b0;
            error_q     <= 1'b0;
            op_tag_q    <= 3'd0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_q       <= '0;
        end else begin
            gnt_q       <= 8'h00;
            op_valid_q  <= 1'b0;
            res_valid_q <= 8'h00;
            if (bus.flush) begin
                state_q <= DRAIN;
                cnt_q   <= 4'(LAT);
                busy_q  <= 8'h00;
                ptr_q   <= 3'd7;
            end else if (state_q == DRAIN) begin
                if (cnt_q <= 4'd1) begin
                    state_q <= RUN;
                    cnt_q   <= 4'd0;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end else begin
                // A return and an issue to different axes in the same cycle both land.
                busy_q      <= (busy_q & ~ret_clr) | issue_set;
                res_valid_q <= ret_clr;
                if (ret_ok) begin
                    res_q[bus.ret_tag] <= bus.ret_data;
                end
                if (bus.ret_valid && !busy_q[bus.ret_tag]) begin
                    error_q <= 1'b1;
                end
                if (pick_any_d) begin
                    gnt_q      <= issue_set;
                    op_valid_q <= 1'b1;
                    op_tag_q   <= pick_idx_d;
                    op_a_q     <= bus.a[pick_idx_d];
                    op_b_q     <= bus.b[pick_idx_d];
                    ptr_q      <= pick_idx_d;
                end
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.op_tag    = op_tag_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.res       = res_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = busy_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_calc_unit_arbiter.sv
// Bench for calc_unit_arbiter: directed scenarios then random traffic, all checked every cycle
// against a behavioural model; a queue stands in for the LAT-cycle multiplier.
module tb_calc_unit_arbiter;
    localparam int W   = 32;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic sclr;

    calc_unit_arbiter_if #(.W(W)) bus ();
    calc_unit_arbiter #(.W(W), .LAT(LAT)) dut (.clk_i(clk), .sclr_i(sclr), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int           due;
        logic [2:0]   tag;
        logic [W-1:0] data;
    } ret_t;
    ret_t uq[$];
    bit         spur = 1'b0;
    logic [2:0] spur_tag = 3'd0;

    bit           m_busy [8];
    bit           m_resv [8];
    logic [W-1:0] m_res  [8];
    int           m_ptr, m_cnt, m_gnt;
    bit           m_draining, m_err;
    logic [2:0]   m_tag;
    logic [W-1:0] m_a, m_b;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_prio(input int i);
`ifdef CALC_ARB_PRIO_EN
        return bus.prio[i];
`else
        return 1'b0;
`endif
    endfunction

    // Next-cycle expectation from the arbitration rules applied to this cycle's inputs.
    task automatic model_step();
        int win;
        int t;
        bit any_prio;
        m_gnt = -1;
        for (int i = 0; i < 8; i++) m_resv[i] = 1'b0;
        if (sclr) begin
            for (int i = 0; i < 8; i++) begin
                m_busy[i] = 1'b0;
                m_res[i]  = '0;
            end
            m_ptr = 7; m_cnt = 0; m_draining = 1'b0; m_err = 1'b0;
            m_tag = 3'd0; m_a = '0; m_b = '0;
        end else if (bus.flush) begin
            for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
            m_ptr = 7; m_cnt = LAT; m_draining = 1'b1;
        end else if (m_draining) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_draining = 1'b0;
        end else begin
            any_prio = 1'b0;
            for (int i = 0; i < 8; i++)
                if (bus.req[i] && !m_busy[i] && in_prio(i)) any_prio = 1'b1;
            win = -1;
            for (int off = 1; off <= 8; off++) begin
                t = (m_ptr + off) % 8;
                if (win < 0 && bus.req[t] && !m_busy[t] && (!any_prio || in_prio(t))) win = t;
            end
            if (bus.ret_valid) begin
                t = int'(bus.ret_tag);
                if (m_busy[t]) begin
                    m_res[t]  = bus.ret_data;
                    m_resv[t] = 1'b1;
                    m_busy[t] = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (win >= 0) begin
                m_busy[win] = 1'b1;
                m_gnt = win;
                m_tag = 3'(win);
                m_a   = bus.a[win];
                m_b   = bus.b[win];
                m_ptr = win;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0]   eb, ev;
        logic [255:0] er;
        er = '0;
        for (int i = 0; i < 8; i++) begin
            eb[i] = m_busy[i];
            ev[i] = m_resv[i];
            er[i*W +: W] = m_res[i];
        end
        check("gnt",       bus.gnt, (m_gnt >= 0) ? 256'(8'b1 << m_gnt) : 256'd0);
        check("op_valid",  bus.op_valid, 256'(m_gnt >= 0));
        check("op_tag",    bus.op_tag, m_tag);
        check("op_a",      bus.op_a, m_a);
        check("op_b",      bus.op_b, m_b);
        check("res_valid", bus.res_valid, ev);
        check("busy",      bus.busy, eb);
        check("error",     bus.error, m_err);
        check("res",       bus.res, er);
    endtask

    task automatic drive_ret();
        if (uq.size() > 0 && uq[0].due == cyc) begin
            bus.ret_valid = 1'b1;
            bus.ret_tag   = uq[0].tag;
            bus.ret_data  = uq[0].data;
            void'(uq.pop_front());
        end else if (spur) begin
            bus.ret_valid = 1'b1;
            bus.ret_tag   = spur_tag;
            bus.ret_data  = W'($urandom);
        end else begin
            bus.ret_valid = 1'b0;
        end
    endtask

    task automatic tick();
        ret_t         r;
        logic [W-1:0] prod;
        drive_ret();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (sclr) uq.delete();
        if (bus.op_valid === 1'b1) begin
            prod = bus.op_a * bus.op_b;
            r.due = cyc + LAT; r.tag = bus.op_tag; r.data = prod;
            uq.push_back(r);
        end
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        sclr = 1'b1; bus.flush = 1'b0; bus.req = 8'h00; spur = 1'b0;
        ticks(2);
        sclr = 1'b0;
    endtask

    task automatic run_until_gnt(input int budget, output int n);
        n = 0;
        do begin tick(); n++; end while (bus.gnt === 8'h00 && n < budget);
    endtask

    task automatic run_until_resv(input int axis, input int budget);
        int n;
        n = 0;
        do begin tick(); n++; end while (bus.res_valid[axis] !== 1'b1 && n < budget);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] s2, s5;
        sclr = 1'b1;
        bus.flush = 1'b0; bus.req = 8'h00; bus.a = '0; bus.b = '0;
        bus.ret_valid = 1'b0; bus.ret_tag = 3'd0; bus.ret_data = '0;
`ifdef CALC_ARB_PRIO_EN
        bus.prio = 8'h00;
`endif
        do_reset();
        check("rst_busy", bus.busy, 8'h00);
        check("rst_error", bus.error, 1'b0);

        // Single request on axis 0.
        bus.req = 8'h01; bus.a[0] = 32'd3; bus.b[0] = 32'd5;
        tick();
        check("single_gnt", bus.gnt, 8'h01);
        check("single_tag", bus.op_tag, 3'd0);
        check("single_a", bus.op_a, 32'd3);
        check("single_b", bus.op_b, 32'd5);
        check("single_busy", bus.busy, 8'h01);
        bus.req = 8'h00;
        run_until_resv(0, 12);
        check("single_resv", bus.res_valid, 8'h01);
        check("single_res", bus.res[0], 32'd15);
        check("single_busy_clr", bus.busy, 8'h00);
        ticks(3);

        // Round-robin fairness with all axes requesting.
        do_reset();
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8; j++) begin
                bus.a[j] = W'($urandom); bus.b[j] = W'($urandom);
            end
            tick();
            check("rr_order", bus.gnt, 8'(8'b1 << (i % 8)));
        end
        bus.req = 8'h00;
        ticks(10);

        // Wrap past axis 7 from ptr = 6.
        do_reset();
        bus.req = 8'h40;
        tick();
        check("wrap_first6", bus.gnt, 8'h40);
        bus.req = 8'h00;
        run_until_resv(6, 12);
        bus.req = 8'h41;
        tick();
        check("wrap_gnt0", bus.gnt, 8'h01);
        bus.req = 8'h40;
        tick();
        check("wrap_gnt6", bus.gnt, 8'h40);
        bus.req = 8'h00;
        ticks(8);

        // Flush with axes 2 and 5 in flight.
        bus.req = 8'h24; bus.a[2] = 32'd7; bus.b[2] = 32'd9; bus.a[5] = 32'd11; bus.b[5] = 32'd13;
        tick();
        check("flush_gnt2", bus.gnt, 8'h04);
        bus.req = 8'h20;
        tick();
        check("flush_gnt5", bus.gnt, 8'h20);
        bus.req = 8'h00;
        tick();
        s2 = m_res[2]; s5 = m_res[5];
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 8'h00);
        check("flush_gnt_off", bus.gnt, 8'h00);
        bus.req = 8'h01;
        run_until_gnt(20, n);
        check("flush_gap", 256'(n >= LAT + 1), 256'd1);
        check("flush_next_gnt", bus.gnt, 8'h01);
        check("flush_res2", bus.res[2], s2);
        check("flush_res5", bus.res[5], s5);
        check("flush_noerr", bus.error, 1'b0);
        bus.req = 8'h00;
        ticks(8);

        // Return to an idle axis is a sticky protocol error.
        spur = 1'b1; spur_tag = 3'd3;
        tick();
        spur = 1'b0;
        check("err_set", bus.error, 1'b1);
        bus.req = 8'hFF;
        ticks(12);
        check("err_sticky", bus.error, 1'b1);
        bus.req = 8'h00;
        ticks(8);
        do_reset();
        check("err_clr", bus.error, 1'b0);

`ifdef CALC_ARB_PRIO_EN
        bus.req = 8'hFF; bus.prio = 8'h10;
        tick();
        check("prio_first", bus.gnt, 8'h10);
        bus.prio = 8'h00;
        tick();
        check("prio_resume", bus.gnt, 8'h20);
        bus.req = 8'h00;
        ticks(8);
`endif

        // Random traffic with occasional flush, spurious return and reset.
        for (int k = 0; k < 600; k++) begin
            sclr      = ($urandom_range(0, 199) == 0);
            bus.flush = ($urandom_range(0, 29) == 0);
            bus.req   = 8'($urandom);
            for (int j = 0; j < 8; j++) begin
                bus.a[j] = W'($urandom); bus.b[j] = W'($urandom);
            end
            spur     = ($urandom_range(0, 39) == 0);
            spur_tag = 3'($urandom);
`ifdef CALC_ARB_PRIO_EN
            bus.prio = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
`endif
            tick();
        end
        sclr = 1'b0; bus.flush = 1'b0; bus.req = 8'h00; spur = 1'b0;
        ticks(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
